tone_arbiter: RTL and testbench

Shares the single buzzer tone generator between three frequency sources: the manual keyboard decoder, the auto-play song player and a fixed-pitch alert beep. Sits between those sources and the PWM tone generator, and drives one 11-bit `frequency` word in the existing Hz encoding, where 1 means silence. Inserts a short silent gap whenever ownership passes between sources. Tells the song player to pause its rhythm counter while it is pre-empted.

---
 rtl/tone_arb_pkg.sv | 54 +++++
 rtl/tone_arb_timer.sv | 34 +++
 rtl/tone_arbiter.sv | 177 +++++++++++++++++
 tb/tb_tone_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/tone_arb_pkg.sv
// Shared types and constants for the buzzer tone arbiter: state codes, grant
// bit positions, the silence code and the low/middle/high do-xi note pitches.
package tone_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_GAP  = 3'd1,
    ST_AUTO = 3'd2,
    ST_KEY  = 3'd3,
    ST_BEEP = 3'd4
  } tone_state_e;

  localparam logic [10:0] SILENCE = 11'd1;

  localparam int G_AUTO = 0;
  localparam int G_KEY  = 1;
  localparam int G_BEEP = 2;

  // Note pitches in Hz, shared with the song player and key decoder.
  localparam logic [10:0] NOTE_L_DO = 11'd262;
  localparam logic [10:0] NOTE_L_RE = 11'd294;
  localparam logic [10:0] NOTE_L_MI = 11'd330;
  localparam logic [10:0] NOTE_L_FA = 11'd349;
  localparam logic [10:0] NOTE_L_SO = 11'd392;
  localparam logic [10:0] NOTE_L_LA = 11'd440;
  localparam logic [10:0] NOTE_L_XI = 11'd494;
  localparam logic [10:0] NOTE_M_DO = 11'd523;
  localparam logic [10:0] NOTE_M_RE = 11'd587;
  localparam logic [10:0] NOTE_M_MI = 11'd659;
  localparam logic [10:0] NOTE_M_FA = 11'd698;
  localparam logic [10:0] NOTE_M_SO = 11'd784;
  localparam logic [10:0] NOTE_M_LA = 11'd880;
  localparam logic [10:0] NOTE_M_XI = 11'd988;
  localparam logic [10:0] NOTE_H_DO = 11'd1046;
  localparam logic [10:0] NOTE_H_RE = 11'd1175;
  localparam logic [10:0] NOTE_H_MI = 11'd1318;
  localparam logic [10:0] NOTE_H_FA = 11'd1397;
  localparam logic [10:0] NOTE_H_SO = 11'd1568;
  localparam logic [10:0] NOTE_H_LA = 11'd1760;
  localparam logic [10:0] NOTE_H_XI = 11'd1976;

  function automatic logic [2:0] grant_of(input logic [2:0] st);
    logic [2:0] g;
    g = 3'b000;
    case (st)
      ST_AUTO: g[G_AUTO] = 1'b1;
      ST_KEY:  g[G_KEY]  = 1'b1;
      ST_BEEP: g[G_BEEP] = 1'b1;
      default: g = 3'b000;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/tone_arb_timer.sv
// Loadable saturating down-counter shared by the GAP, KEY-hold and BEEP
// intervals; done is registered and is high whenever the count sits at zero.
module tone_arb_timer
  import tone_arb_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count_r;

  // Load on state entry, otherwise count down and stick at zero
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= '0;
      done    <= 1'b1;
    end else if (load) begin
      count_r <= load_val;
      done    <= (load_val == '0);
    end else if (count_r != '0) begin
      count_r <= count_r - W'(1);
      done    <= (count_r == W'(1));
    end else begin
      count_r <= count_r;
      done    <= 1'b1;
    end
  end

endmodule

// File: rtl/tone_arbiter.sv
// Buzzer tone arbiter: grants the tone generator to beep > key > auto with a
// silent gap on every handover. Beep source is built only when
// TONE_ARB_BEEP_EN is defined; otherwise priority is key > auto.
module tone_arbiter
  import tone_arb_pkg::*;
#(
  parameter int          GAP_CYCLES  = 50_000,
  parameter int          HOLD_CYCLES = 2_500_000,
  parameter int          BEEP_CYCLES = 25_000_000,
  parameter logic [10:0] BEEP_FREQ   = 11'd1046
) (
  input  logic        CP,
  input  logic        reset,
  input  logic        key_req,
  input  logic [10:0] key_freq,
  input  logic        auto_req,
  input  logic [10:0] auto_freq,
  input  logic        beep_trig,
  output logic [10:0] frequency,
  output logic [2:0]  grant,
  output logic        auto_hold
);

  localparam logic [2:0] S_IDLE = ST_IDLE;
  localparam logic [2:0] S_GAP  = ST_GAP;
  localparam logic [2:0] S_AUTO = ST_AUTO;
  localparam logic [2:0] S_KEY  = ST_KEY;
  localparam logic [2:0] S_BEEP = ST_BEEP;

  localparam int MAX_GH = (GAP_CYCLES > HOLD_CYCLES) ? GAP_CYCLES : HOLD_CYCLES;
`ifdef TONE_ARB_BEEP_EN
  localparam int MAX_ALL = (BEEP_CYCLES > MAX_GH) ? BEEP_CYCLES : MAX_GH;
  localparam logic [2:0] GRANT_MASK = 3'b111;
`else
  localparam int MAX_ALL = MAX_GH;
  localparam logic [2:0] GRANT_MASK = 3'b011;
`endif
  localparam int CNT_W = (MAX_ALL > 2) ? $clog2(MAX_ALL) : 1;

  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  logic [2:0]       state_r;
  logic [2:0]       next_state_s;
  logic [2:0]       arb_s;
  logic             beep_req_s;
  logic             timer_done_s;
  logic             timer_load_s;
  logic [CNT_W-1:0] load_val_s;
  logic [10:0]      freq_next_s;

`ifdef TONE_ARB_BEEP_EN
  localparam logic [CNT_W-1:0] BEEP_LOAD = CNT_W'(BEEP_CYCLES - 1);
  logic beep_pend_r;

  // A trigger arriving this cycle counts immediately so it wins a same-cycle tie.
  assign beep_req_s = beep_pend_r | (beep_trig & (state_r != S_BEEP));

  // Remember a beep request until BEEP is entered; triggers during BEEP are dropped
  always_ff @(posedge CP) begin
    if (reset) begin
      beep_pend_r <= 1'b0;
    end else if (next_state_s == S_BEEP) begin
      beep_pend_r <= 1'b0;
    end else if (beep_trig && (state_r != S_BEEP)) begin
      beep_pend_r <= 1'b1;
    end else begin
      beep_pend_r <= beep_pend_r;
    end
  end
`else
  logic unused_beep_s;
  assign unused_beep_s = ^{beep_trig, BEEP_FREQ, BEEP_CYCLES[0]};
  assign beep_req_s    = 1'b0;
`endif

  assign arb_s = beep_req_s ? S_BEEP :
                 key_req    ? S_KEY  :
                 auto_req   ? S_AUTO : S_IDLE;

  // Next-state selection
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: next_state_s = arb_s;
      S_AUTO: begin
        if (!auto_req) begin
          next_state_s = S_IDLE;
        end else if (beep_req_s || key_req) begin
          next_state_s = S_GAP;
        end else begin
          next_state_s = S_AUTO;
        end
      end
      S_KEY: begin
        if (beep_req_s) begin
          next_state_s = S_GAP;
        end else if (timer_done_s && !key_req) begin
          next_state_s = S_IDLE;
        end else begin
          next_state_s = S_KEY;
        end
      end
      S_BEEP: begin
        if (!timer_done_s) begin
          next_state_s = S_BEEP;
        end else if (key_req || auto_req) begin
          next_state_s = S_GAP;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_GAP: begin
        if (timer_done_s) begin
          next_state_s = arb_s;
        end else begin
          next_state_s = S_GAP;
        end
      end
      default: next_state_s = S_IDLE;
    endcase
  end

  assign timer_load_s = (next_state_s != state_r);

  // Interval length for the state being entered
  always_comb begin
    load_val_s = '0;
    case (next_state_s)
      S_GAP:   load_val_s = GAP_LOAD;
      S_KEY:   load_val_s = HOLD_LOAD;
`ifdef TONE_ARB_BEEP_EN
      S_BEEP:  load_val_s = BEEP_LOAD;
`endif
      default: load_val_s = '0;
    endcase
  end

  // Pitch for the coming cycle; a released key keeps its last sampled pitch
  always_comb begin
    freq_next_s = SILENCE;
    case (next_state_s)
      S_AUTO:  freq_next_s = auto_freq;
      S_KEY:   freq_next_s = key_req ? key_freq : frequency;
`ifdef TONE_ARB_BEEP_EN
      S_BEEP:  freq_next_s = BEEP_FREQ;
`endif
      default: freq_next_s = SILENCE;
    endcase
  end

  // State and registered outputs, aligned to the state register
  always_ff @(posedge CP) begin
    if (reset) begin
      state_r   <= S_IDLE;
      frequency <= SILENCE;
      grant     <= 3'b000;
      auto_hold <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      frequency <= freq_next_s;
      grant     <= grant_of(next_state_s) & GRANT_MASK;
      auto_hold <= auto_req && (next_state_s != S_AUTO);
    end
  end

  tone_arb_timer #(
    .W (CNT_W)
  ) u_timer (
    .clk      (CP),
    .reset    (reset),
    .load     (timer_load_s),
    .load_val (load_val_s),
    .done     (timer_done_s)
  );

endmodule

// File: tb/tb_tone_arbiter.sv
// Scoreboard bench for tone_arbiter with GAP=4, HOLD=8, BEEP=16.
module tb_tone_arbiter;

  logic        CP = 1'b0;
  logic        reset;
  logic        key_req;
  logic [10:0] key_freq;
  logic        auto_req;
  logic [10:0] auto_freq;
  logic        beep_trig;
  logic [10:0] frequency;
  logic [2:0]  grant;
  logic        auto_hold;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [10:0] f;
    logic [2:0]  g;
    logic        h;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;

  tone_arbiter #(
    .GAP_CYCLES  (4),
    .HOLD_CYCLES (8),
    .BEEP_CYCLES (16),
    .BEEP_FREQ   (11'd1046)
  ) dut (
    .CP        (CP),
    .reset     (reset),
    .key_req   (key_req),
    .key_freq  (key_freq),
    .auto_req  (auto_req),
    .auto_freq (auto_freq),
    .beep_trig (beep_trig),
    .frequency (frequency),
    .grant     (grant),
    .auto_hold (auto_hold)
  );

  always #5 CP = ~CP;

  task automatic tick();
    @(posedge CP);
    #1;
  endtask

  task automatic push(input int n, input logic [10:0] f, input logic [2:0] g, input logic h);
    for (int i = 0; i < n; i++) sb_q.push_back({f, g, h});
  endtask

  task automatic test_reset();
    push(2, 11'd1, 3'b000, 1'b0);
    push(2, 11'd523, 3'b001, 1'b0);
    push(1, 11'd587, 3'b001, 1'b0);
    push(1, 11'd1, 3'b000, 1'b0);
    push(1, 11'd587, 3'b001, 1'b0);
    push(1, 11'd1, 3'b000, 1'b0);
    for (int c = 0; c < 8; c++) begin
      reset     = (c < 2) || (c == 5);
      auto_req  = (c >= 2) && (c < 7);
      auto_freq = (c >= 4) ? 11'd587 : 11'd523;
      tick();
      e = sb_q.pop_front();
      checks++;
      if ({frequency, grant, auto_hold} !== {e.f, e.g, e.h}) begin
        failures++;
        $display("FAIL reset cyc=%0d got f=%0d g=%b h=%b want f=%0d g=%b h=%b",
                 c, frequency, grant, auto_hold, e.f, e.g, e.h);
      end
    end
  endtask

  task automatic test_key_preempt();
    push(2, 11'd659, 3'b001, 1'b0);
    push(4, 11'd1, 3'b000, 1'b1);
    push(1, 11'd880, 3'b010, 1'b1);
    push(7, 11'd988, 3'b010, 1'b1);
    push(1, 11'd1, 3'b000, 1'b1);
    push(1, 11'd659, 3'b001, 1'b0);
    push(1, 11'd1, 3'b000, 1'b0);
    auto_freq = 11'd659;
    for (int c = 0; c < 17; c++) begin
      auto_req = (c < 16);
      key_req  = (c >= 2) && (c < 8);
      key_freq = (c >= 7) ? 11'd988 : 11'd880;
      tick();
      e = sb_q.pop_front();
      checks++;
      if ({frequency, grant, auto_hold} !== {e.f, e.g, e.h}) begin
        failures++;
        $display("FAIL key_preempt cyc=%0d got f=%0d g=%b h=%b want f=%0d g=%b h=%b",
                 c, frequency, grant, auto_hold, e.f, e.g, e.h);
      end
    end
  endtask

  task automatic test_key_hold();
    push(8, 11'd784, 3'b010, 1'b0);
    push(1, 11'd1, 3'b000, 1'b0);
    key_freq = 11'd784;
    for (int c = 0; c < 9; c++) begin
      key_req = (c < 2);
      tick();
      e = sb_q.pop_front();
      checks++;
      if ({frequency, grant, auto_hold} !== {e.f, e.g, e.h}) begin
        failures++;
        $display("FAIL key_hold cyc=%0d got f=%0d g=%b h=%b want f=%0d g=%b h=%b",
                 c, frequency, grant, auto_hold, e.f, e.g, e.h);
      end
    end
  endtask

`ifdef TONE_ARB_BEEP_EN
  task automatic test_beep_preempt();
    push(1, 11'd698, 3'b010, 1'b0);
    push(4, 11'd1, 3'b000, 1'b0);
    push(16, 11'd1046, 3'b100, 1'b0);
    push(4, 11'd1, 3'b000, 1'b0);
    push(8, 11'd698, 3'b010, 1'b0);
    push(1, 11'd1, 3'b000, 1'b0);
    key_freq = 11'd698;
    for (int c = 0; c < 34; c++) begin
      key_req   = (c < 26);
      beep_trig = (c == 1);
      tick();
      e = sb_q.pop_front();
      checks++;
      if ({frequency, grant, auto_hold} !== {e.f, e.g, e.h}) begin
        failures++;
        $display("FAIL beep_preempt cyc=%0d got f=%0d g=%b h=%b want f=%0d g=%b h=%b",
                 c, frequency, grant, auto_hold, e.f, e.g, e.h);
      end
    end
  endtask

  task automatic test_beep_in_gap();
    push(1, 11'd523, 3'b001, 1'b0);
    push(4, 11'd1, 3'b000, 1'b1);
    push(16, 11'd1046, 3'b100, 1'b1);
    push(4, 11'd1, 3'b000, 1'b1);
    push(1, 11'd523, 3'b001, 1'b0);
    push(1, 11'd1, 3'b000, 1'b0);
    auto_freq = 11'd523;
    key_freq  = 11'd880;
    for (int c = 0; c < 27; c++) begin
      auto_req  = (c < 26);
      key_req   = (c >= 1) && (c < 22);
      beep_trig = (c == 2) || (c == 8);
      tick();
      e = sb_q.pop_front();
      checks++;
      if ({frequency, grant, auto_hold} !== {e.f, e.g, e.h}) begin
        failures++;
        $display("FAIL beep_in_gap cyc=%0d got f=%0d g=%b h=%b want f=%0d g=%b h=%b",
                 c, frequency, grant, auto_hold, e.f, e.g, e.h);
      end
    end
  endtask

  task automatic test_simultaneous();
    push(16, 11'd1046, 3'b100, 1'b0);
    push(1, 11'd1, 3'b000, 1'b0);
    key_freq = 11'd784;
    for (int c = 0; c < 17; c++) begin
      key_req   = (c == 0);
      beep_trig = (c == 0);
      tick();
      e = sb_q.pop_front();
      checks++;
      if ({frequency, grant, auto_hold} !== {e.f, e.g, e.h}) begin
        failures++;
        $display("FAIL simultaneous cyc=%0d got f=%0d g=%b h=%b want f=%0d g=%b h=%b",
                 c, frequency, grant, auto_hold, e.f, e.g, e.h);
      end
    end
  endtask
`else
  task automatic test_no_beep();
    push(2, 11'd392, 3'b001, 1'b0);
    push(4, 11'd1, 3'b000, 1'b1);
    push(8, 11'd440, 3'b010, 1'b1);
    push(1, 11'd1, 3'b000, 1'b1);
    push(1, 11'd392, 3'b001, 1'b0);
    push(1, 11'd1, 3'b000, 1'b0);
    auto_freq = 11'd392;
    key_freq  = 11'd440;
    for (int c = 0; c < 17; c++) begin
      auto_req  = (c < 16);
      key_req   = (c >= 2) && (c < 8);
      beep_trig = (c == 1) || (c == 7);
      tick();
      e = sb_q.pop_front();
      checks++;
      if ({frequency, grant, auto_hold} !== {e.f, e.g, e.h}) begin
        failures++;
        $display("FAIL no_beep cyc=%0d got f=%0d g=%b h=%b want f=%0d g=%b h=%b",
                 c, frequency, grant, auto_hold, e.f, e.g, e.h);
      end
    end
  endtask
`endif

  initial begin
    reset     = 1'b1;
    key_req   = 1'b0;
    key_freq  = 11'd0;
    auto_req  = 1'b0;
    auto_freq = 11'd0;
    beep_trig = 1'b0;
    #2;
    test_reset();
    test_key_preempt();
    test_key_hold();
`ifdef TONE_ARB_BEEP_EN
    test_beep_preempt();
    test_beep_in_gap();
    test_simultaneous();
`else
    test_no_beep();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
